ex_stage: RTL

- Execute stage of the 5-stage MIPS32 pipeline. It sits directly downstream of the ID/EX pipeline register and consumes that register's aluop/alusel/operand/write-back/link/delay-slot outputs.
- Computes ALU, shift, HI/LO-move and link results combinationally.
- Runs DIV/DIVU on an internal multi-cycle radix-2 divider and raises stallreq until the quotient and remainder are ready.
- Feeds the EX/MEM register.

---
 rtl/ex_stage_pkg.sv | 55 +++++
 rtl/ex_stage_div_unit.sv | 84 ++++++++
 rtl/ex_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared encodings, widths and divider state codes for the execute stage
package ex_stage_pkg;

  localparam logic RstEnable = 1'b0;
  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;
  localparam int RegAddrBus   = 5;
  localparam int AluOpBus     = 8;
  localparam int AluSelBus    = 3;

  localparam logic [7:0] EXE_NOP_OP   = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
  localparam logic [7:0] EXE_LUI_OP   = 8'b01011100;
  localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b00000011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b00101010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b00101011;
  localparam logic [7:0] EXE_ADD_OP   = 8'b00100000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b00100001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b00100010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b00100011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
  localparam logic [7:0] EXE_JR_OP    = 8'b00001000;
  localparam logic [7:0] EXE_JAL_OP   = 8'b01010000;

  localparam logic [2:0] EXE_RES_NOP         = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC       = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT       = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE        = 3'b011;
  localparam logic [2:0] EXE_RES_ARITHMETIC  = 3'b100;
  localparam logic [2:0] EXE_RES_MUL         = 3'b101;
  localparam logic [2:0] EXE_RES_JUMP_BRANCH = 3'b110;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

endpackage

// File: rtl/ex_stage_div_unit.sv
// rtl/ex_stage_div_unit.sv - radix-2 restoring divider, one quotient bit per cycle
module div_unit
  import ex_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                signed_div,
  input  logic [DATA_W-1:0]   opdata1,
  input  logic [DATA_W-1:0]   opdata2,
  output logic [2*DATA_W-1:0] result,
  output logic                ready
);
  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  div_state_t state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2*DATA_W:0] work;        // {partial remainder, dividend/quotient bits}
  logic [DATA_W-1:0] divisor, abs1, abs2, quo, rem;
  logic [DATA_W+1:0] cand, diff;
  logic              neg_quo, neg_rem;

  assign abs1 = (signed_div && opdata1[DATA_W-1]) ? -opdata1 : opdata1;
  assign abs2 = (signed_div && opdata2[DATA_W-1]) ? -opdata2 : opdata2;
  assign cand = work[2*DATA_W:DATA_W-1];
  assign diff = cand - {2'b00, divisor};
  assign quo  = work[DATA_W-1:0];
  assign rem  = work[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state   <= DivFree;
      cnt     <= '0;
      work    <= '0;
      divisor <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        DivFree: if (start) begin
          cnt <= '0;
          if (opdata2 != '0) begin
            work    <= {{(DATA_W+1){1'b0}}, abs1};
            divisor <= abs2;
            neg_quo <= signed_div && (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
            neg_rem <= signed_div && opdata1[DATA_W-1];
          end
        end
        DivByZero: begin
          work    <= '0;
          neg_quo <= 1'b0;
          neg_rem <= 1'b0;
        end
        DivOn: begin
          // borrow out of the trial subtraction means the divisor did not fit
          if (diff[DATA_W+1]) work <= {work[2*DATA_W-1:0], 1'b0};
          else                work <= {diff[DATA_W:0], work[DATA_W-2:0], 1'b1};
          cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DivFree:   if (start) state_nxt = (opdata2 == '0) ? DivByZero : DivOn;
      DivByZero: state_nxt = DivEnd;
      DivOn:     if (cnt == CNT_LAST) state_nxt = DivEnd;
      DivEnd:    state_nxt = DivFree;
      default:   state_nxt = DivFree;
    endcase
  end

  assign ready  = (state == DivEnd);
  assign result = {neg_rem ? -rem : rem, neg_quo ? -quo : quo};

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS32 execute stage: ALU, shifter, HI/LO moves, multiply and iterative divide
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        aluop_i,
  input  logic [2:0]        alusel_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] link_address_i,
  input  logic              is_in_delayslot_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              mem_whilo_i,
  input  logic [DATA_W-1:0] mem_hi_i,
  input  logic [DATA_W-1:0] mem_lo_i,
  input  logic              wb_whilo_i,
  input  logic [DATA_W-1:0] wb_hi_i,
  input  logic [DATA_W-1:0] wb_lo_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              whilo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              is_in_delayslot_o,
  output logic              stallreq_o
);
  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  logic [DATA_W-1:0]   fwd_hi, fwd_lo, sum_res, diff_res;
  logic [DATA_W-1:0]   logic_res, shift_res, move_res, arith_res;
  logic [2*DATA_W-1:0] prod, div_result;
  logic [SH_W-1:0]     sh;
  logic                ov, is_div, div_ready;

  // youngest pending HI/LO write wins
  assign fwd_hi = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
  assign fwd_lo = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);

  assign sh       = reg1_i[SH_W-1:0];
  assign sum_res  = reg1_i + reg2_i;
  assign diff_res = reg1_i - reg2_i;
  assign ov = ((aluop_i == EXE_ADD_OP) && (reg1_i[MSB] == reg2_i[MSB]) && (sum_res[MSB] != reg1_i[MSB]))
           || ((aluop_i == EXE_SUB_OP) && (reg1_i[MSB] != reg2_i[MSB]) && (diff_res[MSB] != reg1_i[MSB]));
  assign prod = (aluop_i == EXE_MULT_OP)
              ? ({{DATA_W{reg1_i[MSB]}}, reg1_i} * {{DATA_W{reg2_i[MSB]}}, reg2_i})
              : ({{DATA_W{1'b0}}, reg1_i} * {{DATA_W{1'b0}}, reg2_i});
  assign is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

  div_unit #(.DATA_W(DATA_W), .DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (is_div && !div_ready),
    .signed_div (aluop_i == EXE_DIV_OP),
    .opdata1    (reg1_i),
    .opdata2    (reg2_i),
    .result     (div_result),
    .ready      (div_ready)
  );

  always_comb begin
    logic_res = '0;
    shift_res = '0;
    move_res  = '0;
    arith_res = '0;
    case (aluop_i)
      EXE_AND_OP:  logic_res = reg1_i & reg2_i;
      EXE_OR_OP:   logic_res = reg1_i | reg2_i;
      EXE_XOR_OP:  logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP:  logic_res = ~(reg1_i | reg2_i);
      EXE_LUI_OP:  logic_res = {reg2_i[DATA_W/2-1:0], {(DATA_W/2){1'b0}}};
      EXE_SLL_OP:  shift_res = reg2_i << sh;
      EXE_SRL_OP:  shift_res = reg2_i >> sh;
      EXE_SRA_OP:  shift_res = $signed(reg2_i) >>> sh;
      EXE_MFHI_OP: move_res  = fwd_hi;
      EXE_MFLO_OP: move_res  = fwd_lo;
      EXE_ADD_OP, EXE_ADDU_OP: arith_res = sum_res;
      EXE_SUB_OP, EXE_SUBU_OP: arith_res = diff_res;
      EXE_SLT_OP:  arith_res = {{(DATA_W-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)};
      EXE_SLTU_OP: arith_res = {{(DATA_W-1){1'b0}}, reg1_i < reg2_i};
      default: ;
    endcase
  end

  always_comb begin
    wd_o              = '0;
    wreg_o            = 1'b0;
    wdata_o           = '0;
    whilo_o           = 1'b0;
    hi_o              = '0;
    lo_o              = '0;
    is_in_delayslot_o = 1'b0;
    stallreq_o        = NoStop;
    if (rst != RstEnable) begin
      wd_o              = wd_i;
      wreg_o            = wreg_i && !ov;
      is_in_delayslot_o = is_in_delayslot_i;
      stallreq_o        = (is_div && !div_ready) ? Stop : NoStop;
      case (alusel_i)
        EXE_RES_LOGIC:       wdata_o = logic_res;
        EXE_RES_SHIFT:       wdata_o = shift_res;
        EXE_RES_MOVE:        wdata_o = move_res;
        EXE_RES_ARITHMETIC:  wdata_o = arith_res;
        EXE_RES_JUMP_BRANCH: wdata_o = link_address_i;
        default:             wdata_o = '0;
      endcase
      case (aluop_i)
        EXE_MTHI_OP: begin whilo_o = 1'b1; hi_o = reg1_i; lo_o = fwd_lo; end
        EXE_MTLO_OP: begin whilo_o = 1'b1; hi_o = fwd_hi; lo_o = reg1_i; end
        EXE_MULT_OP, EXE_MULTU_OP: begin
          whilo_o = 1'b1;
          hi_o    = prod[2*DATA_W-1:DATA_W];
          lo_o    = prod[DATA_W-1:0];
        end
        EXE_DIV_OP, EXE_DIVU_OP: if (div_ready) begin
          whilo_o = 1'b1;
          hi_o    = div_result[2*DATA_W-1:DATA_W];
          lo_o    = div_result[DATA_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
